// File: rtl/dm_store_unit_pkg.sv
// Shared types for the MEM-stage store path: op encodings, byte-enable
// patterns and the write-buffer entry layout.
package dm_store_pkg;

  typedef enum logic [1:0] {
    ST_SW  = 2'b00,
    ST_SB  = 2'b01,
    ST_SH  = 2'b10,
    ST_RSV = 2'b11
  } st_op_e;

  localparam logic [3:0] BE_WORD  = 4'b1111;
  localparam logic [3:0] BE_HALF0 = 4'b0011;
  localparam logic [3:0] BE_HALF1 = 4'b1100;
  localparam logic [3:0] BE_BYTE0 = 4'b0001;

  // Address is held as a word address; the low two bits are always zero on the bus.
  typedef struct packed {
    logic [29:0] addr_w;
    logic [31:0] wdata;
    logic [3:0]  be;
  } wb_entry_t;

endpackage

// File: rtl/dm_store_unit_if.sv
// Store request (M stage) and memory drain handshake signals of dm_store_unit.
// slave: the store unit itself; master: the surrounding pipeline/memory.
interface dm_store_if #(parameter int AW = 32);
  import dm_store_pkg::*;

  logic          st_valid;
  logic          st_ready;
  st_op_e        st_op;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_data;

  logic          mem_req;
  logic          mem_ack;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;

  modport slave (
    input  st_valid, st_op, st_addr, st_data, mem_ack,
    output st_ready, mem_req, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output st_valid, st_op, st_addr, st_data, mem_ack,
    input  st_ready, mem_req, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/dm_store_unit_wbuf_fifo.sv
// Generic DEPTH-entry synchronous FIFO used as the store write buffer.
// Push is ignored when full and pop is ignored when empty.
module dm_wbuf_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage, pointers and occupancy; storage is cleared so the head reads zero out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dm_store_unit.sv
// MEM-stage store unit: aligns sw/sh/sb data into byte lanes, builds the byte
// enable, buffers stores and drains them over a req/ack handshake.
// Optional: define DM_STORE_ALIGN_EXC_EN to drop misaligned SW/SH and pulse exc_ades.
module dm_store_unit
  import dm_store_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  dm_store_if.slave  bus,
  output logic       busy,
  output logic       exc_ades
);

  localparam int EW = $bits(wb_entry_t);

  wb_entry_t   ent;
  wb_entry_t   head;
  logic [EW-1:0] head_bits;
  logic [1:0]  a;
  logic        enq_ok;
  logic        misaligned;
  logic        accept;
  logic        push;
  logic        full;
  logic        empty;

  assign a      = bus.st_addr[1:0];
  assign accept = bus.st_valid && bus.st_ready;
  assign push   = accept && enq_ok && !misaligned;

  // Lane replication and byte-enable generation for the incoming store.
  always_comb begin
    ent        = '0;
    enq_ok     = 1'b0;
    ent.addr_w = 30'(bus.st_addr[AW-1:2]);
    case (bus.st_op)
      ST_SW: begin
        ent.be    = BE_WORD;
        ent.wdata = bus.st_data;
        enq_ok    = 1'b1;
      end
      ST_SH: begin
        ent.be    = a[1] ? BE_HALF1 : BE_HALF0;
        ent.wdata = {2{bus.st_data[15:0]}};
        enq_ok    = 1'b1;
      end
      ST_SB: begin
        ent.be    = BE_BYTE0 << a;
        ent.wdata = {4{bus.st_data[7:0]}};
        enq_ok    = 1'b1;
      end
      default: enq_ok = 1'b0;
    endcase
  end

`ifdef DM_STORE_ALIGN_EXC_EN
  // Misaligned word/half stores are consumed but never reach memory.
  always_comb begin
    misaligned = 1'b0;
    case (bus.st_op)
      ST_SW:   misaligned = (a != 2'b00);
      ST_SH:   misaligned = a[0];
      default: misaligned = 1'b0;
    endcase
  end

  // One-cycle address-error pulse following the accepting edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) exc_ades <= 1'b0;
    else          exc_ades <= accept && misaligned;
  end
`else
  assign misaligned = 1'b0;
  assign exc_ades   = 1'b0;
`endif

  dm_wbuf_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_wbuf (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .din     (ent),
    .pop     (bus.mem_ack),
    .dout    (head_bits),
    .full    (full),
    .empty   (empty)
  );

  // Memory side is driven only from buffered head state.
  assign head          = head_bits;
  assign bus.st_ready  = !full;
  assign bus.mem_req   = !empty;
  assign busy          = !empty;
  assign bus.mem_addr  = {head.addr_w[AW-3:0], 2'b00};
  assign bus.mem_wdata = head.wdata;
  assign bus.mem_be    = head.be;

endmodule

// File: tb/tb_dm_store_unit.sv
// Scoreboard bench for dm_store_unit: stimulus pushes expected memory writes,
// a negedge monitor pops and compares on every accepted mem_req.
module tb_dm_store_unit;
  import dm_store_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  logic busy;
  logic exc_ades;
  int   checks = 0;
  int   failures = 0;
  int   pop_count = 0;
  int   cyc = 0;
  int   last_pop_cyc = 0;
  exp_t sb_q[$];

  dm_store_if #(.AW(32)) bus ();

  dm_store_unit #(.DEPTH(2), .AW(32)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .busy     (busy),
    .exc_ades (exc_ades)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every accepted head is compared against the oldest expectation.
  always @(negedge clk) begin
    if (reset_n && bus.mem_req && bus.mem_ack) begin
      pop_count++;
      last_pop_cyc = cyc;
      if (sb_q.size() == 0) begin
        check("unexpected_pop", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("mem_addr", bus.mem_addr, e.addr);
        check("mem_wdata", bus.mem_wdata, e.wdata);
        check("mem_be", {28'd0, bus.mem_be}, {28'd0, e.be});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Present one store; returns #1 after the accepting edge.
  task automatic issue(input st_op_e op, input logic [31:0] addr, input logic [31:0] data,
                       input bit enq, input logic [31:0] ea, input logic [31:0] ew,
                       input logic [3:0] ebe);
    int n = 0;
    exp_t e;
    bus.st_valid = 1'b1;
    bus.st_op    = op;
    bus.st_addr  = addr;
    bus.st_data  = data;
    @(negedge clk);
    while (!bus.st_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!bus.st_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      bus.st_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (enq) begin
      e.addr = ea; e.wdata = ew; e.be = ebe;
      sb_q.push_back(e);
    end
    #1 bus.st_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (bus.mem_req && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("drain_timeout", {31'd0, bus.mem_req}, 32'd0);
  endtask

  initial begin
    int p0;
    int t0;
    reset_n      = 1'b0;
    bus.st_valid = 1'b0;
    bus.st_op    = ST_SW;
    bus.st_addr  = '0;
    bus.st_data  = '0;
    bus.mem_ack  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_exc", {31'd0, exc_ades}, 32'd0);
    check("rst_st_ready", {31'd0, bus.st_ready}, 32'd1);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_mem_be", {28'd0, bus.mem_be}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // SB latency and busy fall
    bus.mem_ack = 1'b1;
    issue(ST_SB, 32'h1003, 32'h0000_00A5, 1'b1, 32'h1000, 32'hA5A5_A5A5, 4'b1000);
    @(negedge clk);
    check("sb_latency_req", {31'd0, bus.mem_req}, 32'd1);
    check("sb_busy_high", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("sb_busy_low", {31'd0, busy}, 32'd0);
    check("sb_req_low", {31'd0, bus.mem_req}, 32'd0);
    @(posedge clk); #1;

    // Lane patterns, streamed with ack held high
    issue(ST_SH, 32'h2002, 32'h1234_BEEF, 1'b1, 32'h2000, 32'hBEEF_BEEF, 4'b1100);
    issue(ST_SB, 32'h1001, 32'h0000_0077, 1'b1, 32'h1000, 32'h7777_7777, 4'b0010);
    issue(ST_SH, 32'h0000, 32'hCAFE_1234, 1'b1, 32'h0000, 32'h1234_1234, 4'b0011);
    issue(ST_SW, 32'h0044, 32'hDEAD_BEEF, 1'b1, 32'h0044, 32'hDEAD_BEEF, 4'b1111);
    issue(ST_SB, 32'h0102, 32'h1234_56C3, 1'b1, 32'h0100, 32'hC3C3_C3C3, 4'b0100);
    wait_drain();

    // Reserved op is consumed without a write
    @(posedge clk); #1;
    p0 = pop_count;
    issue(ST_RSV, 32'h0050, 32'h5555_5555, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("rsv_no_req", {31'd0, bus.mem_req}, 32'd0);
    @(negedge clk);
    check("rsv_no_pop", pop_count - p0, 32'd0);

    // Fill with ack low, head holds, then release with a push in the same cycle
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    issue(ST_SW, 32'h0010, 32'h1111_1111, 1'b1, 32'h0010, 32'h1111_1111, 4'b1111);
    issue(ST_SW, 32'h0014, 32'h2222_2222, 1'b1, 32'h0014, 32'h2222_2222, 4'b1111);
    @(negedge clk);
    check("full_st_ready", {31'd0, bus.st_ready}, 32'd0);
    check("full_head_addr", bus.mem_addr, 32'h0010);
    repeat (3) @(negedge clk);
    check("hold_head_addr", bus.mem_addr, 32'h0010);
    check("hold_head_wdata", bus.mem_wdata, 32'h1111_1111);
    @(posedge clk); #1;
    bus.mem_ack = 1'b1;
    issue(ST_SW, 32'h0018, 32'h3333_3333, 1'b1, 32'h0018, 32'h3333_3333, 4'b1111);
    wait_drain();

    // Full buffer streaming: one pop per cycle, pushes only when ready
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    issue(ST_SW, 32'h0020, 32'hA000_0020, 1'b1, 32'h0020, 32'hA000_0020, 4'b1111);
    issue(ST_SW, 32'h0024, 32'hA000_0024, 1'b1, 32'h0024, 32'hA000_0024, 4'b1111);
    bus.mem_ack = 1'b1;
    t0 = cyc;
    p0 = pop_count;
    issue(ST_SW, 32'h0028, 32'hA000_0028, 1'b1, 32'h0028, 32'hA000_0028, 4'b1111);
    issue(ST_SB, 32'h002D, 32'h0000_002C, 1'b1, 32'h002C, 32'h2C2C_2C2C, 4'b0010);
    issue(ST_SH, 32'h0032, 32'h0000_3030, 1'b1, 32'h0030, 32'h3030_3030, 4'b1100);
    issue(ST_SW, 32'h0034, 32'hA000_0034, 1'b1, 32'h0034, 32'hA000_0034, 4'b1111);
    wait_drain();
    check("stream_pops", pop_count - p0, 32'd6);
    check("stream_span", last_pop_cyc - t0, 32'd5);

    // Misaligned word store
    @(posedge clk); #1;
`ifdef DM_STORE_ALIGN_EXC_EN
    issue(ST_SW, 32'h3001, 32'h55AA_55AA, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("exc_pulse", {31'd0, exc_ades}, 32'd1);
    check("exc_no_req", {31'd0, bus.mem_req}, 32'd0);
    @(negedge clk);
    check("exc_pulse_end", {31'd0, exc_ades}, 32'd0);
    check("exc_still_no_req", {31'd0, bus.mem_req}, 32'd0);
`else
    issue(ST_SW, 32'h3001, 32'h55AA_55AA, 1'b1, 32'h3000, 32'h55AA_55AA, 4'b1111);
    @(negedge clk);
    check("noexc_pulse", {31'd0, exc_ades}, 32'd0);
    check("noexc_req", {31'd0, bus.mem_req}, 32'd1);
    @(posedge clk); #1;
    issue(ST_SH, 32'h3003, 32'h0000_9876, 1'b1, 32'h3000, 32'h9876_9876, 4'b1100);
`endif
    wait_drain();

    // Reset mid-drain drops the buffer
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    issue(ST_SW, 32'h0040, 32'hB000_0040, 1'b1, 32'h0040, 32'hB000_0040, 4'b1111);
    issue(ST_SW, 32'h0044, 32'hB000_0044, 1'b1, 32'h0044, 32'hB000_0044, 4'b1111);
    @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #1;
    reset_n = 1'b0;
    bus.mem_ack = 1'b1;
    #1;
    check("rst_drop_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst_drop_busy", {31'd0, busy}, 32'd0);
    check("rst_drop_ready", {31'd0, bus.st_ready}, 32'd1);
    sb_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", {31'd0, bus.st_ready}, 32'd1);
    p0 = pop_count;
    issue(ST_SW, 32'h0048, 32'h1357_9BDF, 1'b1, 32'h0048, 32'h1357_9BDF, 4'b1111);
    wait_drain();
    check("post_rst_single", pop_count - p0, 32'd1);

    repeat (2) @(negedge clk);
    check("queue_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_store_unit.md
Name: dm_store_unit

Overview:
- Store-side counterpart of the load extractor in the MEM stage of the 5-stage MIPS32 CPU.
- Accepts sw/sb/sh requests from the M stage and replicates the store data into byte lanes.
- Generates the 4-bit byte enable and queues each store in a small write buffer.
- Drains the buffer to data memory / bridge over a req/ack handshake.

Parameters:
- DEPTH, 2, write-buffer entries (power of 2, ≥2).
- AW, 32, byte address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- st_valid  in  1  M stage presents a store.
- st_ready  out  1  buffer can accept; equals !full.
- st_op  in  2  store type, encoding from package.
- st_addr  in  AW  byte address.
- st_data  in  32  rt register value, unaligned.
- mem_req  out  1  head entry valid.
- mem_ack  in  1  memory accepted the head this cycle.
- mem_addr  out  AW  word-aligned address, bits[1:0]=0.
- mem_wdata  out  32  lane-replicated data.
- mem_be  out  4  byte enables, bit i = byte lane i.
- busy  out  1  buffer non-empty; the hazard unit stalls loads while high.
- exc_ades  out  1  store address-error pulse (see Optional Feature).

Behaviour:
- Reset: the buffer empties asynchronously when reset_n falls.
  - mem_req=0, busy=0, exc_ades=0, st_ready=1.
  - mem_addr/mem_wdata/mem_be=0.
  - An in-flight req is dropped. Memory must ignore an ack that arrives while reset is asserted.
- Accept on st_valid && st_ready at a rising edge.
  - st_ready=0 only when count==DEPTH.
  - There is no bypass: a push while full is impossible.
- Alignment, computed before enqueue. Let a = st_addr[1:0].
  - SW: be=4'b1111, wdata=st_data.
  - SH: be = a[1] ? 4'b1100 : 4'b0011, wdata={2{st_data[15:0]}}.
  - SB: be = 4'b0001 << a, wdata={4{st_data[7:0]}}.
  - Reserved op 2'b11: the request is accepted (handshake completes) but nothing is enqueued.
- Drain:
  - mem_req=!empty. mem_addr/wdata/be come from head registers only; there is no combinational path from st_* to mem_*.
  - The head pops on mem_req && mem_ack.
  - Entries stay stable while mem_req is high and mem_ack is low.
- Latency: a store accepted at edge N appears on mem_req after edge N (earliest cycle N+1).
- Order: strictly FIFO. Pointers wrap modulo DEPTH. count width is clog2(DEPTH)+1.
- Simultaneous push and pop: count unchanged, both pointers advance. Allowed at any non-empty count, including full-then-pop (st_ready was low that cycle, so no push).
- Pop when empty: impossible, since mem_req=0.
- busy is registered state (!empty). It deasserts the cycle after the last pop.

Optional Feature:
- Macro: DM_STORE_ALIGN_EXC_EN.
- When defined:
  - SH with a[0]=1, or SW with a≠0, is accepted but not enqueued.
  - exc_ades pulses high for exactly one cycle after the accepting edge.
  - A pulse for a request accepted while full cannot occur, since no accept happens then.
- When undefined:
  - exc_ades is tied 0.
  - SW ignores a (be=1111).
  - SH uses a[1] only.

Decomposition:
- Package dm_store_pkg holds:
  - op encodings ST_SW=2'b00, ST_SB=2'b01, ST_SH=2'b10, ST_RSV=2'b11;
  - BE_WORD/BE_HALF0/BE_HALF1 constants;
  - the entry struct {addr word, wdata, be}.
- One natural sub-module: dm_wbuf_fifo, a generic DEPTH-entry synchronous FIFO with async active-low reset, push/pop/full/empty. It is instantiated once. Alignment logic stays in the top.

Test Plan:
- SB addr=0x1003, data=0x000000A5, mem_ack=1 → next cycle mem_req=1, mem_addr=0x1000, mem_be=1000, mem_wdata=0xA5A5A5A5; busy drops one cycle after ack.
- SH addr=0x2002, data=0x1234BEEF → mem_be=1100, mem_wdata=0xBEEFBEEF.
- Hold mem_ack=0, push SW 0x10, SW 0x14 → st_ready=0 after the 2nd accept, head stays 0x10. Then mem_ack=1 with st_valid SW 0x18 the same cycle → order 0x10, 0x14, 0x18, no loss.
- Full buffer with mem_ack=1 and st_valid=1 each cycle → exactly one pop per cycle; push happens only on cycles when st_ready=1.
- With DM_STORE_ALIGN_EXC_EN: SW addr=0x3001 → exc_ades=1 for one cycle, mem_req stays 0. Without the macro: mem_addr=0x3000, be=1111.
- Assert reset_n=0 mid-drain with 2 entries → mem_req and busy fall immediately. After release, st_ready=1 and a single SW drains alone.
